mux_serializer8: RTL and testbench

- Parallel-to-serial stage built around the existing 8-to-1 multiplexer.
- Accepts an 8-bit word over a valid/ready handshake and holds it in a register.
- Steps the 3-bit mux select through all eight positions and emits one bit per bit-period on a serial output.
- Sits directly upstream of serial consumers and owns the select sequencing that the mux itself lacks.

---
 rtl/mux_serializer8_pkg.sv | 12 +
 rtl/mux_serializer8_if.sv | 36 +++
 rtl/mux_serializer8_mux8to1.sv | 12 +
 rtl/mux_serializer8.sv | 112 +++++++++++
 tb/tb_mux_serializer8.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_serializer8_pkg.sv
// Shared types and widths for the 8-bit parallel-to-serial stage.
package mux_serializer8_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

endpackage

// File: rtl/mux_serializer8_if.sv
// Handshake and serial-side signals of the serializer, bundled for port use.
interface mux_serializer8_if;
    import mux_serializer8_pkg::*;

    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  sel;
    logic              ser_out;
    logic              ser_valid;
    logic              busy;
    logic              done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  sel,
        input  ser_out,
        input  ser_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output sel,
        output ser_out,
        output ser_valid,
        output busy,
        output done
    );

endinterface

// File: rtl/mux_serializer8_mux8to1.sv
// Plain 8-to-1 bit multiplexer: y = w[s].
module mux8to1
    import mux_serializer8_pkg::*;
(
    input  logic [WORD_W-1:0] w,
    input  logic [SEL_W-1:0]  s,
    output logic              y
);

    assign y = w[s];

endmodule

// File: rtl/mux_serializer8.sv
// Accepts a byte over valid/ready and shifts it out one bit per BIT_CYCLES
// clocks by stepping the mux select; back-to-back words leave no gap.
module mux_serializer8
    import mux_serializer8_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_serializer8_if.slave bus
);

    localparam int                CNT_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [SEL_W-1:0]  SEL_FIRST = MSB_FIRST ? SEL_W'(WORD_W - 1) : SEL_W'(0);
    localparam logic [SEL_W-1:0]  SEL_FINAL = MSB_FIRST ? SEL_W'(0) : SEL_W'(WORD_W - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [WORD_W-1:0] r_data;
    logic [SEL_W-1:0]  r_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;

    logic w_cnt_term;
    logic w_last;
    logic w_ready;
    logic w_accept;
    logic w_shift;
    logic w_mux_y;

    assign w_shift    = (r_state == SHIFT);
    assign w_cnt_term = (r_cnt == CNT_LAST);
    // Final bit-period of the final select position of the current word.
    assign w_last     = w_shift && w_cnt_term && (r_sel == SEL_FINAL);
    assign w_accept   = bus.in_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_ready = 1'b1;
                    if (!bus.in_valid) begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_sel  <= SEL_FIRST;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_data <= bus.in_data;
                r_sel  <= SEL_FIRST;
                r_cnt  <= '0;
            end else if (w_shift) begin
                if (w_last) begin
                    // Park select at its start value so sel never leaves 0..7.
                    r_sel <= SEL_FIRST;
                    r_cnt <= '0;
                end else if (w_cnt_term) begin
                    r_cnt <= '0;
                    r_sel <= MSB_FIRST ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    mux8to1 u_mux (
        .w (r_data),
        .s (r_sel),
        .y (w_mux_y)
    );

    assign bus.in_ready  = w_ready;
    assign bus.sel       = r_sel;
    assign bus.ser_valid = w_shift;
    assign bus.busy      = w_shift;
    assign bus.done      = r_done;
    assign bus.ser_out   = w_shift ? w_mux_y : IDLE_LEVEL;

endmodule

// File: tb/tb_mux_serializer8.sv
// Three serializer configurations checked cycle by cycle against a
// word/position reference model plus directed scenario expectations.
module tb_mux_serializer8;

    logic clk;
    logic rst_n;

    mux_serializer8_if if0 ();
    mux_serializer8_if if1 ();
    mux_serializer8_if if2 ();

    // DUT 0: LSB first, 1 cycle/bit. DUT 1: MSB first, 1 cycle/bit. DUT 2: LSB first, 4 cycles/bit.
    mux_serializer8 #(.BIT_CYCLES(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mux_serializer8 #(.BIT_CYCLES(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mux_serializer8 #(.BIT_CYCLES(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [7:0] drv_data [3];
    logic [2:0] drv_valid;

    assign if0.in_data  = drv_data[0];
    assign if1.in_data  = drv_data[1];
    assign if2.in_data  = drv_data[2];
    assign if0.in_valid = drv_valid[0];
    assign if1.in_valid = drv_valid[1];
    assign if2.in_valid = drv_valid[2];

    logic [2:0] obs_out, obs_valid, obs_ready, obs_busy, obs_done;
    logic [2:0] obs_sel [3];

    assign obs_out   = {if2.ser_out,   if1.ser_out,   if0.ser_out};
    assign obs_valid = {if2.ser_valid, if1.ser_valid, if0.ser_valid};
    assign obs_ready = {if2.in_ready,  if1.in_ready,  if0.in_ready};
    assign obs_busy  = {if2.busy,      if1.busy,      if0.busy};
    assign obs_done  = {if2.done,      if1.done,      if0.done};
    assign obs_sel[0] = if0.sel;
    assign obs_sel[1] = if1.sel;
    assign obs_sel[2] = if2.sel;

    int cmp_cnt = 0;
    int err_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a word in flight and the cycle index k within it.
    logic [2:0] m_active;
    logic [2:0] m_done;
    logic [7:0] m_word [3];
    int         m_k    [3];

    function automatic int bc_of(input int d);
        return (d == 2) ? 4 : 1;
    endfunction

    function automatic bit msb_of(input int d);
        return (d == 1);
    endfunction

    function automatic int last_k(input int d);
        return 8 * bc_of(d) - 1;
    endfunction

    function automatic logic [2:0] exp_sel(input int d);
        int pos;
        pos = m_k[d] / bc_of(d);
        return msb_of(d) ? 3'(7 - pos) : 3'(pos);
    endfunction

    function automatic logic exp_ready(input int d);
        return !m_active[d] || (m_k[d] == last_k(d));
    endfunction

    function automatic logic exp_out(input int d);
        logic [7:0] w;
        w = m_word[d];
        return m_active[d] ? w[exp_sel(d)] : 1'b1;
    endfunction

    function automatic logic [7:0] exp_vec(input int d);
        return {exp_out(d), m_active[d], exp_ready(d), m_active[d], m_done[d],
                (m_active[d] ? exp_sel(d) : 3'd0)};
    endfunction

    function automatic logic [7:0] obs_vec(input int d);
        return {obs_out[d], obs_valid[d], obs_ready[d], obs_busy[d], obs_done[d],
                (m_active[d] ? obs_sel[d] : 3'd0)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= '0;
            m_done   <= '0;
            for (int d = 0; d < 3; d++) begin
                m_word[d] <= '0;
                m_k[d]    <= 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                m_done[d] <= m_active[d] && (m_k[d] == last_k(d));
                if (drv_valid[d] && exp_ready(d)) begin
                    m_word[d]   <= drv_data[d];
                    m_k[d]      <= 0;
                    m_active[d] <= 1'b1;
                end else if (m_active[d]) begin
                    if (m_k[d] == last_k(d)) m_active[d] <= 1'b0;
                    else                     m_k[d] <= m_k[d] + 1;
                end
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b1;
        drv_valid = '0;
        for (int d = 0; d < 3; d++) drv_data[d] = 8'h00;
        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            cmp_cnt++;
            if ({obs_out[d], obs_valid[d], obs_ready[d], obs_busy[d], obs_done[d], obs_sel[d]} !==
                {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, (msb_of(d) ? 3'd7 : 3'd0)}) begin
                err_cnt++;
                $display("FAIL reset_state dut=%0d got=%b required=%b", d,
                         {obs_out[d], obs_valid[d], obs_ready[d], obs_busy[d], obs_done[d], obs_sel[d]},
                         {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, (msb_of(d) ? 3'd7 : 3'd0)});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: initial state checked on all configurations");
    endtask

    task automatic test_lsb_first;
        logic [7:0] got;
        int nv, nd;
        got = '0; nv = 0; nd = 0;
        @(negedge clk);
        drv_valid[0] = 1'b1; drv_data[0] = 8'hA5;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            drv_valid[0] = 1'b0;
            cmp_cnt++;
            if (obs_vec(0) !== exp_vec(0)) begin
                err_cnt++;
                $display("FAIL lsb_cycle c=%0d got=%b required=%b", c, obs_vec(0), exp_vec(0));
            end
            if (obs_valid[0]) begin
                if (nv < 8) got[nv] = obs_out[0];
                nv++;
            end
            if (obs_done[0]) begin
                nd++;
                cmp_cnt++;
                if (c != 8) begin
                    err_cnt++;
                    $display("FAIL lsb_done_cycle got=%0d required=8", c);
                end
            end
        end
        cmp_cnt++;
        if ({got, 8'(nv), 8'(nd)} !== {8'hA5, 8'd8, 8'd1}) begin
            err_cnt++;
            $display("FAIL lsb_word got=%h/%0d/%0d required=a5/8/1", got, nv, nd);
        end
        $display("lsb word a5: bits=%h valid_cycles=%0d done_pulses=%0d", got, nv, nd);
    endtask

    task automatic test_msb_first;
        logic [7:0] got;
        int nv;
        got = '0; nv = 0;
        @(negedge clk);
        drv_valid[1] = 1'b1; drv_data[1] = 8'h0F;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            drv_valid[1] = 1'b0;
            cmp_cnt++;
            if (obs_vec(1) !== exp_vec(1)) begin
                err_cnt++;
                $display("FAIL msb_cycle c=%0d got=%b required=%b", c, obs_vec(1), exp_vec(1));
            end
            if (obs_valid[1]) begin
                cmp_cnt++;
                if (obs_sel[1] !== 3'(7 - nv)) begin
                    err_cnt++;
                    $display("FAIL msb_sel c=%0d got=%0d required=%0d", c, obs_sel[1], 7 - nv);
                end
                got = {got[6:0], obs_out[1]};
                nv++;
            end
        end
        cmp_cnt++;
        if (got !== 8'h0F) begin
            err_cnt++;
            $display("FAIL msb_word got=%h required=0f", got);
        end
        $display("msb word 0f: stream=%h valid_cycles=%0d", got, nv);
    endtask

    task automatic test_back_to_back;
        logic [15:0] got;
        int nv, nd, nr, acc;
        got = '0; nv = 0; nd = 0; nr = 0; acc = 1;
        @(negedge clk);
        drv_valid[0] = 1'b1; drv_data[0] = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cmp_cnt++;
            if (obs_vec(0) !== exp_vec(0)) begin
                err_cnt++;
                $display("FAIL b2b_cycle c=%0d got=%b required=%b", c, obs_vec(0), exp_vec(0));
            end
            if (obs_valid[0]) begin
                if (nv < 16) got[nv] = obs_out[0];
                nv++;
            end
            if (obs_done[0]) nd++;
            if (c < 15 && obs_ready[0]) nr++;
            if (acc >= 2) drv_valid[0] = 1'b0;
            else          drv_data[0] = 8'h00;
            if (drv_valid[0] && exp_ready(0)) acc++;
        end
        cmp_cnt++;
        if ({got, 8'(nv), 8'(nd), 8'(nr)} !== {16'h00FF, 8'd16, 8'd2, 8'd1}) begin
            err_cnt++;
            $display("FAIL b2b_stream got=%h/%0d/%0d/%0d required=00ff/16/2/1", got, nv, nd, nr);
        end
        $display("back-to-back ff,00: stream=%h valid_cycles=%0d done_pulses=%0d", got, nv, nd);
    endtask

    task automatic test_slow_bits;
        logic [31:0] got;
        int nv, nd;
        got = '0; nv = 0; nd = 0;
        @(negedge clk);
        drv_valid[2] = 1'b1; drv_data[2] = 8'h81;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            drv_valid[2] = 1'b0;
            cmp_cnt++;
            if (obs_vec(2) !== exp_vec(2)) begin
                err_cnt++;
                $display("FAIL slow_cycle c=%0d got=%b required=%b", c, obs_vec(2), exp_vec(2));
            end
            if (obs_valid[2]) begin
                if (nv < 32) got[nv] = obs_out[2];
                nv++;
            end
            if (obs_done[2]) nd++;
        end
        cmp_cnt++;
        if ({got, 8'(nv), 8'(nd)} !== {32'hF000000F, 8'd32, 8'd1}) begin
            err_cnt++;
            $display("FAIL slow_word got=%h/%0d/%0d required=f000000f/32/1", got, nv, nd);
        end
        $display("4-cycle bits word 81: stream=%h valid_cycles=%0d", got, nv);
    endtask

    task automatic test_busy_reject;
        logic [7:0] got;
        int nv, nd;
        got = '0; nv = 0; nd = 0;
        @(negedge clk);
        drv_valid[0] = 1'b1; drv_data[0] = 8'h5A;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            cmp_cnt++;
            if (obs_vec(0) !== exp_vec(0)) begin
                err_cnt++;
                $display("FAIL reject_cycle c=%0d got=%b required=%b", c, obs_vec(0), exp_vec(0));
            end
            if (obs_valid[0]) begin
                if (nv < 8) got[nv] = obs_out[0];
                nv++;
            end
            if (obs_done[0]) nd++;
            drv_valid[0] = (c >= 1 && c <= 4);
            drv_data[0]  = 8'h3C;
        end
        cmp_cnt++;
        if ({got, 8'(nv), 8'(nd)} !== {8'h5A, 8'd8, 8'd1}) begin
            err_cnt++;
            $display("FAIL reject_word got=%h/%0d/%0d required=5a/8/1", got, nv, nd);
        end
        $display("busy reject: kept word=%h while 3c offered", got);
    endtask

    task automatic test_reset_mid_word;
        logic [7:0] word, got;
        int nv, nd;
        word = 8'($urandom_range(0, 255));
        got = '0; nv = 0; nd = 0;
        @(negedge clk);
        drv_valid[0] = 1'b1; drv_data[0] = 8'hC3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drv_valid[0] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if ({obs_out[0], obs_valid[0], obs_ready[0], obs_busy[0], obs_done[0]} !== 5'b10100) begin
            err_cnt++;
            $display("FAIL midreset_async got=%b required=10100",
                     {obs_out[0], obs_valid[0], obs_ready[0], obs_busy[0], obs_done[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (obs_done[0]) nd++;
        end
        cmp_cnt++;
        if (nd != 0) begin
            err_cnt++;
            $display("FAIL midreset_done got=%0d pulses required=0", nd);
        end
        drv_valid[0] = 1'b1; drv_data[0] = word;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drv_valid[0] = 1'b0;
            cmp_cnt++;
            if (obs_vec(0) !== exp_vec(0)) begin
                err_cnt++;
                $display("FAIL midreset_after c=%0d got=%b required=%b", c, obs_vec(0), exp_vec(0));
            end
            if (obs_valid[0]) begin
                if (nv < 8) got[nv] = obs_out[0];
                nv++;
            end
        end
        cmp_cnt++;
        if (got !== word) begin
            err_cnt++;
            $display("FAIL midreset_word got=%h required=%h", got, word);
        end
        $display("reset mid-word: recovered word=%h", got);
    endtask

    task automatic test_random;
        int accepts;
        accepts = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                cmp_cnt++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    err_cnt++;
                    $display("FAIL random dut=%0d c=%0d got=%b required=%b", d, c, obs_vec(d), exp_vec(d));
                end
                drv_valid[d] = ($urandom_range(0, 99) < 60);
                drv_data[d]  = 8'($urandom_range(0, 255));
                if (drv_valid[d] && exp_ready(d)) accepts++;
            end
        end
        @(negedge clk);
        drv_valid = '0;
        $display("random: 600 cycles, %0d words accepted across configurations", accepts);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_slow_bits();
        test_busy_reject();
        test_reset_mid_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
